// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / forwarding controller.
package hazard_pkg;

  localparam int unsigned REG_BITS = 5;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EX      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  localparam logic [REG_BITS-1:0] REG_ZERO = 5'd0;

  // One in-flight destination record per pipeline stage.
  typedef struct packed {
    logic                v;
    logic [REG_BITS-1:0] rd;
    logic                we;
    logic                ld;
  } stage_rec_t;

endpackage

// File: rtl/cmp.sv
// Generic equality comparator.
module cmp #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/hu_stage_match.sv
// Matches one stage's destination record against the ID source registers.
module hu_stage_match
  import hazard_pkg::*;
(
  input  stage_rec_t          rec,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  output logic                match_rs,
  output logic                match_rt
);

  logic eq_rs;
  logic eq_rt;
  logic live;

  cmp #(.W(REG_BITS)) u_cmp_rs (
    .a  (rec.rd),
    .b  (id_rs),
    .eq (eq_rs)
  );

  cmp #(.W(REG_BITS)) u_cmp_rt (
    .a  (rec.rd),
    .b  (id_rt),
    .eq (eq_rt)
  );

  // $0 is hardwired, so a write to it never produces a forwardable value.
  assign live     = id_valid && rec.v && rec.we && (rec.rd != REG_ZERO);
  assign match_rs = live && eq_rs && id_use_rs;
  assign match_rt = live && eq_rt && id_use_rt;

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall and EX operand forwarding control for the 5-stage core.
// REG_W must equal hazard_pkg::REG_BITS; the stage records use the package width.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_load,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_count
);

  stage_rec_t       ex_q, mem_q, wb_q;
  stage_rec_t       ex_d;
  logic [2:0]       m_rs, m_rt;
  logic [CNT_W-1:0] cnt_q;

  hu_stage_match u_match_ex (
    .rec       (ex_q),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .match_rs  (m_rs[0]),
    .match_rt  (m_rt[0])
  );

  hu_stage_match u_match_mem (
    .rec       (mem_q),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .match_rs  (m_rs[1]),
    .match_rt  (m_rt[1])
  );

  hu_stage_match u_match_wb (
    .rec       (wb_q),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .match_rs  (m_rs[2]),
    .match_rt  (m_rt[2])
  );

  // Only a load still in EX is too late to forward; MEM/WB loads forward normally.
  assign stall = id_valid && !flush && ex_q.ld && (m_rs[0] || m_rt[0]);

  always_comb begin
    fwd_rs_sel = FWD_REGFILE;
    if (m_rs[0])      fwd_rs_sel = FWD_EX;
    else if (m_rs[1]) fwd_rs_sel = FWD_MEM;
    else if (m_rs[2]) fwd_rs_sel = FWD_WB;
  end

  always_comb begin
    fwd_rt_sel = FWD_REGFILE;
    if (m_rt[0])      fwd_rt_sel = FWD_EX;
    else if (m_rt[1]) fwd_rt_sel = FWD_MEM;
    else if (m_rt[2]) fwd_rt_sel = FWD_WB;
  end

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.v  = 1'b1;
      ex_d.rd = id_rd;
      ex_d.we = id_we;
      ex_d.ld = id_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a model.
module tb_hazard_unit;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       flush;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_we;
  logic       id_load;
  logic       stall;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;
  logic [3:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Model: last three issue slots, index 0 = youngest (EX).
  logic       m_v  [3];
  logic [4:0] m_rd [3];
  logic       m_we [3];
  logic       m_ld [3];
  int         mcnt;

  logic       obs_stall;
  logic [1:0] obs_rs;
  logic [1:0] obs_rt;
  logic [3:0] obs_cnt;

  hazard_unit #(
    .REG_W (5),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hold        (hold),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_load     (id_load),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic mmatch(input int k, input logic [4:0] x, input logic use_x);
    return id_valid && m_v[k] && m_we[k] && (m_rd[k] != 5'd0) && (m_rd[k] == x) && use_x;
  endfunction

  function automatic logic [1:0] msel(input logic [4:0] x, input logic use_x);
    for (int k = 0; k < 3; k++) begin
      if (mmatch(k, x, use_x)) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_rd[k] = 5'd0; m_we[k] = 1'b0; m_ld[k] = 1'b0;
    end
    mcnt = 0;
  endtask

  // Drive one cycle of ID inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic r, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] rd, input logic we,
                      input logic ld, input logic fl, input logic hd);
    logic es;
    rst_n = r; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_we = we; id_load = ld; flush = fl; hold = hd;
    @(negedge clk);
    es = v && !fl && m_ld[0] && (mmatch(0, rs, urs) || mmatch(0, rt, urt));
    obs_stall = stall; obs_rs = fwd_rs_sel; obs_rt = fwd_rt_sel; obs_cnt = stall_count;
    chk("stall", 32'(obs_stall), 32'(es));
    chk("fwd_rs_sel", 32'(obs_rs), 32'(msel(rs, urs)));
    chk("fwd_rt_sel", 32'(obs_rt), 32'(msel(rt, urt)));
    chk("stall_count", 32'(obs_cnt), 32'(mcnt));
    @(posedge clk);
    if (!r) begin
      model_clear();
    end else if (!hd) begin
      if (es) mcnt = (mcnt == CNT_MAX) ? CNT_MAX : mcnt + 1;
      for (int k = 2; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_we[k] = m_we[k-1]; m_ld[k] = m_ld[k-1];
      end
      if (v && !es && !fl) begin
        m_v[0] = 1'b1; m_rd[0] = rd; m_we[0] = we; m_ld[0] = ld;
      end else begin
        m_v[0] = 1'b0; m_rd[0] = 5'd0; m_we[0] = 1'b0; m_ld[0] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_rd = '0; id_we = 1'b0; id_load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Reset state with a reading instruction in ID.
    step(1, 1, 5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("rst_stall", 32'(obs_stall), 32'd0);
    chk("rst_rs", 32'(obs_rs), 32'd0);
    chk("rst_cnt", 32'(obs_cnt), 32'd0);

    // Forward chain EX -> MEM -> WB.
    step(1, 1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0, 0);
    step(1, 1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0);
    chk("chain_ex_rs", 32'(obs_rs), 32'd1);
    chk("chain_ex_rt", 32'(obs_rt), 32'd1);
    chk("chain_ex_stall", 32'(obs_stall), 32'd0);
    step(1, 1, 5'd3, 5'd3, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("chain_mem_rs", 32'(obs_rs), 32'd2);
    step(1, 1, 5'd3, 5'd3, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("chain_wb_rt", 32'(obs_rt), 32'd3);

    // Load-use: one stall, then forward from MEM.
    step(1, 1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);
    step(1, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0);
    chk("lu_stall", 32'(obs_stall), 32'd1);
    step(1, 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0);
    chk("lu_after_stall", 32'(obs_stall), 32'd0);
    chk("lu_after_rs", 32'(obs_rs), 32'd2);
    chk("lu_after_cnt", 32'(obs_cnt), 32'd1);

    // Zero register never matches, even for a load.
    step(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0);
    step(1, 1, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("zero_rs", 32'(obs_rs), 32'd0);
    chk("zero_rt", 32'(obs_rt), 32'd0);
    chk("zero_stall", 32'(obs_stall), 32'd0);

    // Priority: youngest writer wins; bubble in EX falls back to MEM.
    repeat (3) step(1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0);
    step(1, 1, 5'd0, 5'd7, 0, 1, 5'd0, 0, 0, 0, 0);
    chk("prio_ex", 32'(obs_rt), 32'd1);
    repeat (2) step(1, 1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 0, 0, 0);
    step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    step(1, 1, 5'd0, 5'd7, 0, 1, 5'd0, 0, 0, 0, 0);
    chk("prio_mem", 32'(obs_rt), 32'd2);

    // Flush suppresses the stall and leaves a bubble in EX.
    step(1, 1, 5'd0, 5'd0, 0, 0, 5'd10, 1, 1, 0, 0);
    step(1, 1, 5'd10, 5'd0, 1, 0, 5'd9, 1, 0, 1, 0);
    chk("flush_stall", 32'(obs_stall), 32'd0);
    step(1, 1, 5'd9, 5'd10, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("flush_bubble_rs", 32'(obs_rs), 32'd0);
    chk("flush_load_rt", 32'(obs_rt), 32'd2);

    // Hold during a load-use stall freezes everything.
    step(1, 1, 5'd0, 5'd0, 0, 0, 5'd11, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5'd11, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);
      chk("hold_stall", 32'(obs_stall), 32'd1);
      chk("hold_cnt", 32'(obs_cnt), 32'd1);
    end
    step(1, 1, 5'd11, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    chk("unhold_stall", 32'(obs_stall), 32'd1);
    step(1, 1, 5'd11, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    chk("unhold_cnt", 32'(obs_cnt), 32'd2);
    chk("unhold_rs", 32'(obs_rs), 32'd2);

    // Saturation: 17 stall cycles from zero leave the counter at all-ones.
    step(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 5'd0, 5'd0, 0, 0, 5'd12, 1, 1, 0, 0);
      step(1, 1, 5'd12, 5'd12, 1, 1, 5'd0, 0, 0, 0, 0);
    end
    step(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
    chk("sat_cnt", 32'(obs_cnt), 32'd15);

    // Reset mid-operation discards records and the counter.
    step(1, 1, 5'd0, 5'd0, 0, 0, 5'd13, 1, 1, 0, 0);
    step(0, 1, 5'd13, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
    step(1, 1, 5'd13, 5'd13, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("mid_rst_rs", 32'(obs_rs), 32'd0);
    chk("mid_rst_stall", 32'(obs_stall), 32'd0);
    chk("mid_rst_cnt", 32'(obs_cnt), 32'd0);

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
           ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS core; sits between decode (ID) and the EX operand muxes.
- Keeps a shift pipeline of in-flight destination-register records for the EX, MEM and WB stages.
- Compares ID source registers (rs/rt) against those records and drives load-use stall and per-operand forwarding selects.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_W, 5, register-number width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active low.
- hold  in  1  global freeze (memory wait); tracking pipeline holds.
- flush  in  1  kill the ID instruction (taken branch/jump); insert a bubble into EX.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs  in  REG_W  source register A.
- id_rt  in  REG_W  source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_rd  in  REG_W  destination register.
- id_we  in  1  instruction writes id_rd.
- id_load  in  1  instruction is a load (lw).
- stall  out  1  hold PC/IF/ID and bubble EX (combinational).
- fwd_rs_sel  out  2  operand-A source: 0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB result.
- fwd_rt_sel  out  2  operand-B source, same encoding.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: three records (EX, MEM, WB), each holding {v, rd, we, ld}.
- Reset, sampled at the clk edge with rst_n = 0: all v = 0; rd, we, ld = 0; stall_count = 0. Outputs after reset: stall = 0, fwd sel = 0.
- Match rule for stage S against source X:
  - S.v && S.we && S.rd != 0 && S.rd == X && use_X && id_valid.
  - Register $0 never matches.
- Forward select priority is youngest first: EX (1) > MEM (2) > WB (3), else 0.
- stall = id_valid && !flush && EX.ld && (EX match on rs || EX match on rt).
  - A load matched in MEM or WB forwards normally (2 or 3); it does not stall.
- fwd sel outputs are computed even when stall = 1. The consumer ignores them while stalled.
- Update each clk edge, when rst_n = 1 and hold = 0:
  - WB <= MEM; MEM <= EX.
  - EX <= {1, id_rd, id_we, id_load} if id_valid && !stall && !flush.
  - Otherwise EX <= bubble (v = 0, other fields 0).
- hold = 1: all records and stall_count keep their values. stall and fwd sel stay combinationally valid.
- hold = 1 and flush = 1 in the same cycle: hold wins (nothing shifts). The owner of flush must keep it asserted until hold drops.
- stall_count increments by 1 on every edge with rst_n = 1, hold = 0, stall = 1. It saturates at all-ones; no wrap.
- Latency:
  - Forwarding and stall are zero-cycle (combinational from ID inputs and registered records).
  - A record advances one stage per non-held cycle.
- Load-use sequence: 1 stall cycle, then the dependent instruction sees the load in MEM and gets sel = 2.
- Reset mid-operation discards all in-flight records. There is no partial state.

Decomposition:
- Shared package hazard_pkg:
  - FWD_REGFILE = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2, FWD_WB = 2'd3.
  - Stage-record struct {v, rd, we, ld}.
  - REG_ZERO = 5'd0.
- One sub-module, hu_stage_match (3 instances, one per stage):
  - Takes one stage record plus id_rs/id_rt/use bits.
  - Returns match_rs and match_rt.
  - Register equality uses the existing 5-bit cmp equality comparator (2 per instance).

Test Plan:
- Forward chain: add $3 (we), then add $4 = $3 + $3 in the next cycle.
  - Required: fwd_rs_sel = fwd_rt_sel = 1, stall = 0.
  - One cycle later, the same sources with $3 in MEM give sel = 2. The cycle after, WB gives sel = 3.
- Load-use: lw $5 in EX, ID reads rs = $5.
  - Required: stall = 1 for exactly one cycle. EX becomes a bubble. Next cycle fwd_rs_sel = 2, stall = 0, stall_count = 1.
- Zero register: EX writes rd = 0 with we = 1, ID reads rs = rt = 0.
  - Required: fwd sel = 0/0, stall = 0, even when ld = 1.
- Priority: $7 is written in EX, MEM and WB simultaneously, ID reads rt = $7.
  - Required: fwd_rt_sel = 1. Clearing EX.v (bubble) gives 2.
- Flush/hold:
  - flush = 1 with id_valid = 1: EX.v = 0 next cycle and stall = 0.
  - hold = 1 for 3 cycles during a load-use stall: records frozen, stall_count unchanged, stall stays 1.
  - After hold drops, count increments once.
- Saturation/reset:
  - Preload toward all-ones with CNT_W = 4: 16 stall cycles leave stall_count = 15.
  - rst_n = 0 for one edge: all sel = 0, stall = 0, count = 0.
